// File: rtl/tc0480scp_vram_sched.sv
// tc0480scp_vram_sched
// Per-line VRAM slot sequencer for the TC0480SCP tilemap core.
// One slot code is produced per ce tick. A line starts with a 16-slot header
// (stall, row select/zoom, row scroll), followed by 16-slot tile groups.
// A single CPU requester is slotted into slots 16 and 24 of each group.
//
// Parameters:
//   GROUPS     tile groups fetched per line before going idle (1..63)
//   HDR_STALL  stall slots at the start of the header (0..4)
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   ce           pixel clock enable; state advances only when ce=1
//   line_end     1-tick pulse at end of active line
//   cpu_req      pulse: CPU RAM access requested
//   slot         current slot code (0-15 header, 16-31 tile group)
//   slot_valid   slot is a real access (0 while idle or in stall)
//   group        current tile group index
//   cpu_grant    current slot carries the CPU access
//   cpu_ack      1-tick pulse on the ce tick after cpu_grant
//   line_strobe  1-tick pulse on the tick after header slot 15
//   tile_load    1-tick pulse on the ticks after slots 21 and 29
//   busy         CPU request pending, not yet acked
//   fsm_state    sequencer state (0 idle, 1 header, 2 tile)
//
// Build option: define TC0480SCP_SCHED_CPU_IDLE_EN to also grant the CPU in
// header stall slots 0-3 and on every idle tick.
//
// Handshake: cpu_req is a one-clock pulse; the request is held pending until
// a grant slot comes up, and cpu_ack marks completion. A request that lands
// while one is pending, or on the same clock as cpu_ack, is dropped.
module tc0480scp_vram_sched #(
    parameter int GROUPS    = 40,
    parameter int HDR_STALL = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       line_end,
    input  logic       cpu_req,
    output logic [4:0] slot,
    output logic       slot_valid,
    output logic [5:0] group,
    output logic       cpu_grant,
    output logic       cpu_ack,
    output logic       line_strobe,
    output logic       tile_load,
    output logic       busy,
    output logic [1:0] fsm_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        TILE = 2'd2
    } state_t;

    localparam logic [4:0] FIRST_SLOT = 5'(4 - HDR_STALL);
    localparam logic [5:0] LAST_GROUP = 6'(GROUPS - 1);
`ifdef TC0480SCP_SCHED_CPU_IDLE_EN
    localparam logic IDLE_GRANT = 1'b1;
`else
    localparam logic IDLE_GRANT = 1'b0;
`endif

    state_t     state;
    logic       pending;
    logic       ack_r;     // registered ack, presented for the slot after the grant
    logic       ls_r;
    logic       tl_r;
    logic       le_pend;   // line_end seen on a non-ce clock, applied at the next tick
    logic       le;
    logic       want_grant;
    logic [4:0] next_slot;

    // A request arriving on the clock of the tick still qualifies; a grant in
    // flight or an ack being delivered blocks a second grant for the same request.
    assign want_grant = (pending | cpu_req) & ~ack_r & ~cpu_grant;
    assign le         = line_end | le_pend;
    assign next_slot  = slot + 5'd1;

    assign cpu_ack     = ack_r & ce;
    assign line_strobe = ls_r & ce;
    assign tile_load   = tl_r & ce;
    assign busy        = pending | (cpu_req & ~cpu_ack & ~reset);
    assign fsm_state   = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            slot       <= 5'd0;
            slot_valid <= 1'b0;
            group      <= 6'd0;
            cpu_grant  <= 1'b0;
            pending    <= 1'b0;
            ack_r      <= 1'b0;
            ls_r       <= 1'b0;
            tl_r       <= 1'b0;
            le_pend    <= 1'b0;
        end else begin
            if (ce && ack_r)
                pending <= 1'b0;
            else if (cpu_req)
                pending <= 1'b1;

            if (ce) begin
                le_pend   <= 1'b0;
                ack_r     <= cpu_grant;   // a granted slot always completes, even across line_end
                cpu_grant <= 1'b0;
                ls_r      <= 1'b0;
                tl_r      <= 1'b0;
                if (le) begin
                    state      <= HDR;
                    slot       <= FIRST_SLOT;
                    slot_valid <= (FIRST_SLOT >= 5'd4);
                    group      <= 6'd0;
                    cpu_grant  <= IDLE_GRANT && (FIRST_SLOT < 5'd4) && want_grant;
                end else begin
                    case (state)
                        IDLE: begin
                            slot       <= 5'd0;
                            slot_valid <= 1'b0;
                            if (IDLE_GRANT && want_grant) begin
                                slot      <= 5'd16;
                                cpu_grant <= 1'b1;
                            end
                        end
                        HDR: begin
                            if (slot == 5'd15) begin
                                state      <= TILE;
                                slot       <= 5'd16;
                                slot_valid <= 1'b1;
                                group      <= 6'd0;
                                ls_r       <= 1'b1;
                                cpu_grant  <= want_grant;
                            end else begin
                                slot       <= next_slot;
                                slot_valid <= (next_slot >= 5'd4);
                                cpu_grant  <= IDLE_GRANT && (next_slot < 5'd4) && want_grant;
                            end
                        end
                        TILE: begin
                            if (slot == 5'd21 || slot == 5'd29)
                                tl_r <= 1'b1;
                            if (slot == 5'd31) begin
                                if (group == LAST_GROUP) begin
                                    // group stays at its last value while idle
                                    state      <= IDLE;
                                    slot       <= 5'd0;
                                    slot_valid <= 1'b0;
                                    if (IDLE_GRANT && want_grant) begin
                                        slot      <= 5'd16;
                                        cpu_grant <= 1'b1;
                                    end
                                end else begin
                                    group     <= group + 6'd1;
                                    slot      <= 5'd16;
                                    cpu_grant <= want_grant;
                                end
                            end else begin
                                slot      <= next_slot;
                                cpu_grant <= (next_slot == 5'd24) && want_grant;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end else if (line_end) begin
                le_pend <= 1'b1;
            end
        end
    end
endmodule
